// File: rtl/half_adder_pkg.sv
// Shared constants and types for the activity-monitored half adder.
// Holds the default toggle-counter width, the counter type at that width
// and the saturation value the counters stop at.
package half_adder_pkg;

  localparam int CNT_W_DEF = 16;

  typedef logic [CNT_W_DEF-1:0] tgl_cnt_t;

  // All-ones: counters hold here instead of wrapping back to zero.
  localparam tgl_cnt_t TGL_CNT_SAT = '1;

endpackage

// File: rtl/half_adder_act_toggle_counter.sv
// Per-cycle toggle counter: one history flop, change detect, saturating count.
// Latency: a change sampled at edge N is visible on cnt after edge N.
// Backpressure: none; cnt is readable at any time.
// Ports: clk/rst_n (async active-low), clr (sync clear, wins over a toggle),
//        din (monitored signal), cnt (saturating toggle count).
module toggle_counter
  import half_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic             hist_q;
  logic             hist_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // History always tracks the input, even on a clearing edge.
    hist_d = din;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if ((din != hist_q) && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/half_adder_act.sv
// Single-bit half adder with optional sum/carry switching-activity counters.
// Latency: sum/carry combinational; toggle counts registered (visible after the sampling edge).
// Backpressure: none; counters are free-running and readable at any time.
// Ports: a, b -> sum, carry; clk, rst_n (async active-low), cnt_clr (sync clear);
//        sum_tgl_cnt, carry_tgl_cnt (CNT_W-bit saturating toggle counts).
// Build option: define HALF_ADDER_ACT_CNT_EN to include the counters; otherwise
// no flops exist and both counts read 0.
module half_adder_act
  import half_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             sum,
  output logic             carry,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sum_tgl_cnt,
  output logic [CNT_W-1:0] carry_tgl_cnt
);

  assign sum   = a ^ b;
  assign carry = a & b;

`ifdef HALF_ADDER_ACT_CNT_EN
  toggle_counter #(.CNT_W(CNT_W)) u_sum_tgl (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .din   (sum),
    .cnt   (sum_tgl_cnt)
  );

  toggle_counter #(.CNT_W(CNT_W)) u_carry_tgl (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .din   (carry),
    .cnt   (carry_tgl_cnt)
  );
`else
  // Clock, reset and clear have no loads in this build.
  logic unused_cnt_ctrl;
  assign unused_cnt_ctrl = &{1'b0, clk, rst_n, cnt_clr};

  assign sum_tgl_cnt   = '0;
  assign carry_tgl_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder_act.sv
module tb_half_adder_act;

`ifdef HALF_ADDER_ACT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic cnt_clr = 1'b0;

  logic        sum16, carry16, sum4, carry4;
  logic [15:0] s_cnt16, c_cnt16;
  logic [3:0]  s_cnt4, c_cnt4;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: unbounded toggle counts; saturation applied when compared.
  int m_sum_prev = 0;
  int m_car_prev = 0;
  int m_sum_n = 0;
  int m_car_n = 0;

  half_adder_act #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sum(sum16), .carry(carry16),
    .cnt_clr(cnt_clr), .sum_tgl_cnt(s_cnt16), .carry_tgl_cnt(c_cnt16)
  );

  half_adder_act #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sum(sum4), .carry(carry4),
    .cnt_clr(cnt_clr), .sum_tgl_cnt(s_cnt4), .carry_tgl_cnt(c_cnt4)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    if (!CNT_EN) return 0;
    return (n > lim) ? lim : n;
  endfunction

  function automatic int lit(input int v);
    return CNT_EN ? v : 0;
  endfunction

  // Reference: the two-bit arithmetic sum a+b gives {carry,sum}.
  always @(posedge clk or negedge rst_n) begin
    int tot, s, c;
    if (!rst_n) begin
      m_sum_prev = 0; m_car_prev = 0; m_sum_n = 0; m_car_n = 0;
    end else begin
      tot = int'(a) + int'(b);
      s = tot % 2;
      c = tot / 2;
      if (cnt_clr) begin
        m_sum_n = 0; m_car_n = 0;
      end else begin
        if (s != m_sum_prev) m_sum_n++;
        if (c != m_car_prev) m_car_n++;
      end
      m_sum_prev = s;
      m_car_prev = c;
    end
  end

  // Compare process: every falling edge once the clock is running.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sum16",   int'(sum16),   (int'(a) + int'(b)) % 2);
      chk("carry16", int'(carry16), (int'(a) + int'(b)) / 2);
      chk("sum4",    int'(sum4),    (int'(a) + int'(b)) % 2);
      chk("s_cnt16", int'(s_cnt16), exp_cnt(m_sum_n, 16));
      chk("c_cnt16", int'(c_cnt16), exp_cnt(m_car_n, 16));
      chk("s_cnt4",  int'(s_cnt4),  exp_cnt(m_sum_n, 4));
      chk("c_cnt4",  int'(c_cnt4),  exp_cnt(m_car_n, 4));
    end
  end

  // Apply inputs, then step past the next rising edge.
  task automatic drive(input bit ia, input bit ib, input bit iclr);
    a = ia; b = ib; cnt_clr = iclr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lit(input string tag, input int s16, input int c16, input int s4, input int c4);
    chk({tag, "_s16"}, int'(s_cnt16), lit(s16));
    chk({tag, "_c16"}, int'(c_cnt16), lit(c16));
    chk({tag, "_s4"},  int'(s_cnt4),  lit(s4));
    chk({tag, "_c4"},  int'(c_cnt4),  lit(c4));
  endtask

  initial begin
    int exp_s[4];
    int exp_c[4];
    exp_s = '{0, 1, 1, 0};
    exp_c = '{0, 0, 0, 1};

    // Combinational sweep with no clock and reset held.
    for (int i = 0; i < 4; i++) begin
      {a, b} = 2'(i);
      #10;
      chk($sformatf("comb_sum_%0d", i),   int'(sum16),   exp_s[i]);
      chk($sformatf("comb_carry_%0d", i), int'(carry16), exp_c[i]);
    end
    chk_lit("rst", 0, 0, 0, 0);

    a = 1'b0; b = 1'b0;
    #3;
    rst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    cmp_en = 1'b1;

    // 00 x5, 01, 11.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk_lit("seq", 2, 1, 2, 1);

    // Clear, then alternate 00/11 for 20 edges.
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) drive(i % 2 == 1, i % 2 == 1, 1'b0);
    chk_lit("alt", 0, 20, 0, 15);

    // Clear on an edge where carry toggles: clear wins.
    drive(1'b0, 1'b0, 1'b1);
    chk_lit("clr_carry", 0, 0, 0, 0);

    // Toggle sum every edge for 20 edges: 4-bit counter sticks at 15.
    for (int i = 0; i < 20; i++) drive(1'b0, i % 2 == 0, 1'b0);
    chk_lit("sat", 20, 0, 15, 0);

    // Clear on a sum toggle, then one more toggle.
    drive(1'b0, 1'b1, 1'b1);
    chk_lit("clr_sum", 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk_lit("post_clr", 1, 0, 1, 0);

    // Asynchronous reset pulse between edges.
    drive(1'b1, 1'b1, 1'b0);
    chk_lit("pre_rst", 1, 1, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_lit("rst_low", 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk_lit("rst_rel", 0, 0, 0, 0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    drive(1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/half_adder_act.md
# half_adder_act

Single-bit half adder with built-in switching-activity monitoring for the power-estimation flow. The `sum` and `carry` outputs are purely combinational. Clocked toggle counters record how many cycles each output changed value, and the estimator reads these counts as activity factors. The block is a leaf cell; higher-level adders and the activity-collection fabric instantiate it.

## Interface
Parameters:
- `CNT_W`, default 16: width of each toggle counter (legal range 4..32).

Ports:
- `clk`, input, 1: single clock; all sequential logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `a`, input, 1: addend A.
- `b`, input, 1: addend B.
- `sum`, output, 1: `a XOR b`, combinational.
- `carry`, output, 1: `a AND b`, combinational.
- `cnt_clr`, input, 1: synchronous clear of both counters, active high.
- `sum_tgl_cnt`, output, `CNT_W`: count of cycles on which `sum` toggled.
- `carry_tgl_cnt`, output, `CNT_W`: count of cycles on which `carry` toggled.

## Operation
- `sum` = `a ^ b` and `carry` = `a & b` at all times, independent of `clk` and `rst_n`. Truth table:
  - 00 → sum 0, carry 0
  - 01 → sum 1, carry 0
  - 10 → sum 1, carry 0
  - 11 → sum 0, carry 1
- History registers `sum_q` and `carry_q` capture `sum` and `carry` on every rising edge.
- Toggle condition: `sum != sum_q` at the sampling edge. Same rule for `carry`.
- Each counter increments by 1 on an edge where its toggle condition holds.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `cnt_clr` = 1: both counters load 0 on that edge, and the clear wins over a simultaneous toggle. The history registers still update normally.
- Input changes between edges that return to the original value before the next edge are not counted. Counting is per-cycle sampled, not glitch-accurate.

## Timing
- Arithmetic outputs have zero latency (combinational).
- Counter outputs are registered. A toggle sampled at edge N is visible after edge N.
- Reset (`rst_n` low, asynchronous): `sum_q` = 0, `carry_q` = 0, both counters = 0, immediately with no clock required. `sum` and `carry` keep following the inputs during reset.
- Reset release: the first edge compares against the reset history values 0/0. If `a` ≠ `b` at that edge, `sum_tgl_cnt` becomes 1.
- Reset asserted mid-count: the counters drop to 0 at once, and no partial count is retained.
- No handshake exists. Counters are readable at any time.

## Configuration
- `HALF_ADDER_ACT_CNT_EN` defined: history registers, toggle counters and the `cnt_clr` logic are compiled in as described above.
- Not defined: no flops are generated, `sum_tgl_cnt` and `carry_tgl_cnt` are tied to 0, and `cnt_clr`, `clk` and `rst_n` are ignored. `sum` and `carry` behave identically in both builds.

## Structure
- Package `half_adder_pkg` holds:
  - the default `CNT_W` constant (16);
  - `typedef logic [CNT_W-1:0] tgl_cnt_t`;
  - the saturation value constant.
- Sub-module `toggle_counter` contains one history flop, the comparator, the saturating counter and the clear logic. `half_adder_act` instantiates it twice, once for `sum` and once for `carry`.

## Test plan
- Combinational sweep, 10 ns per step, inputs ab = 00, 01, 10, 11 → (sum, carry) = (0,0), (1,0), (1,0), (0,1). Must hold with no clock running and with `rst_n` held low.
- Reset then ab=00 for 5 cycles, then ab=01 for 1 cycle, then ab=11 for 1 cycle → `sum_tgl_cnt` = 2 and `carry_tgl_cnt` = 1.
- Alternate ab between 00 and 11 every cycle for 20 cycles → `carry_tgl_cnt` = 20 and `sum_tgl_cnt` = 0.
- `CNT_W` = 4, toggle `sum` every cycle for 20 cycles → `sum_tgl_cnt` stops at 15 and does not wrap.
- Assert `cnt_clr` on a cycle where `sum` toggles → both counters are 0 after that edge. The next toggle then yields 1.
- Counters nonzero, pulse `rst_n` low between edges → counters read 0 before the next edge. Build without `HALF_ADDER_ACT_CNT_EN` → counters always read 0.
